data_sync_mc: RTL and testbench

DATA_SYNC_MC -- requirements
Module: data_sync_mc

---
 rtl/data_sync_mc.sv | 171 +++++++++++++++++
 tb/tb_data_sync_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_sync_mc
// Description : Multi-channel enable-qualified data synchronizer. Each channel
//               synchronizes its asynchronous enable and captures its data
//               slice on a detected enable event. Captured words are then
//               delivered one at a time through a round-robin arbitrated
//               valid/ready output stage. Lost words are flagged per channel
//               in sticky overrun bits.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_mc #(
    parameter int WIDTH       = 8,
    parameter int N           = 2,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = 0
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic [NUM_CH*WIDTH-1:0]                    unsync_bus,
    input  logic [NUM_CH-1:0]                          bus_enable,
    input  logic                                       out_ready,
    output logic                                       out_valid,
    output logic [WIDTH-1:0]                           out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic [NUM_CH-1:0]                          overrun,
    input  logic                                       overrun_clr
);

    localparam int C_CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Per-channel status gathered from the channel generate block
    logic [NUM_CH-1:0] w_cap;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_ovr_set;
    logic [WIDTH-1:0]  w_hold [NUM_CH];

    // Arbiter / output stage
    logic              w_load;
    logic              w_found;
    logic [C_CW-1:0]   w_grant;
    logic [C_CW-1:0]   r_last;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [C_CW-1:0]   r_out_ch;
    logic [NUM_CH-1:0] r_overrun;

    // ------------------------------------------------------------------------
    // Per-channel synchronizer, event detector and holding register
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [N-1:0]     r_sync;
        logic             r_edge;
        logic [WIDTH-1:0] r_hold;
        logic             r_pend;
        logic             w_sync_q;

        assign w_sync_q = r_sync[N-1];

        // Shift the asynchronous enable through the N-flop chain, then one
        // more flop so the synchronized level can be compared with its past.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_sync <= '0;
                r_edge <= 1'b0;
            end else begin
                r_sync <= {r_sync[N-2:0], bus_enable[c]};
                r_edge <= w_sync_q;
            end
        end

        if (TOGGLE_MODE != 0) begin : g_toggle
            assign w_cap[c] = w_sync_q ^ r_edge;
        end else begin : g_rise
            assign w_cap[c] = w_sync_q & ~r_edge;
        end

        // Capture the data slice on an enable event. A capture always wins
        // over a grant, so a word arriving while the old one is handed to the
        // output stays pending rather than being dropped.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_hold <= '0;
                r_pend <= 1'b0;
            end else if (w_cap[c]) begin
                r_hold <= unsync_bus[c*WIDTH +: WIDTH];
                r_pend <= 1'b1;
            end else if (w_gnt[c]) begin
                r_pend <= 1'b0;
            end
        end

        // Overwriting an undelivered word loses it, unless that word is
        // being moved to the output on this very edge.
        assign w_ovr_set[c] = w_cap[c] & r_pend & ~w_gnt[c];
        assign w_pend[c]    = r_pend;
        assign w_hold[c]    = r_hold;
    end

    // ------------------------------------------------------------------------
    // Round-robin arbiter and output stage
    // ------------------------------------------------------------------------
    assign w_load = (~r_out_valid | out_ready) & (|w_pend);

    // Search pending channels starting one past the last grant, wrapping.
    always_comb begin
        int              w_idx;
        logic [C_CW-1:0] w_sel;
        w_idx   = 0;
        w_sel   = '0;
        w_found = 1'b0;
        w_grant = r_last;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            w_sel = C_CW'(w_idx);
            if (!w_found && w_pend[w_sel]) begin
                w_found = 1'b1;
                w_grant = w_sel;
            end
        end
    end

    // One-hot grant strobe, only meaningful on a real output load
    always_comb begin
        w_gnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_gnt[c] = w_load & w_found & (w_grant == C_CW'(c));
        end
    end

    // Output register: load a new word when empty or being accepted,
    // otherwise drop valid on acceptance and keep the payload stable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_last      <= C_CW'(NUM_CH - 1);
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_hold[w_grant];
            r_out_ch    <= w_grant;
            r_last      <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky overrun flags; a new overrun beats a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overrun <= '0;
        end else if (overrun_clr) begin
            r_overrun <= w_ovr_set;
        end else begin
            r_overrun <= r_overrun | w_ovr_set;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_data_sync_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_sync_mc
// Description : Self-checking bench for data_sync_mc. One instance runs in
//               rising-edge mode, a second in toggle mode. Expected words are
//               queued as stimulus is driven; a monitor queues observed
//               handshakes and each scenario task compares the two.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sync_mc;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] bus, bus_t;
    logic [3:0]  en, en_t;
    logic        out_ready, overrun_clr;
    logic        out_valid, out_valid_t;
    logic [7:0]  out_data, out_data_t;
    logic [1:0]  out_ch, out_ch_t;
    logic [3:0]  overrun, overrun_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  data;
        logic [31:0] cyc;
    } item_t;

    item_t       exp_q[$], obs_q[$], exp_t_q[$], obs_t_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;

    always #5 CLK = ~CLK;

    data_sync_mc #(.WIDTH(8), .N(2), .NUM_CH(4), .TOGGLE_MODE(0)) dut (
        .CLK(CLK), .RST(RST), .unsync_bus(bus), .bus_enable(en),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    data_sync_mc #(.WIDTH(8), .N(2), .NUM_CH(4), .TOGGLE_MODE(1)) dut_t (
        .CLK(CLK), .RST(RST), .unsync_bus(bus_t), .bus_enable(en_t),
        .out_ready(out_ready), .out_valid(out_valid_t), .out_data(out_data_t),
        .out_ch(out_ch_t), .overrun(overrun_t), .overrun_clr(overrun_clr)
    );

    // Record every accepted word, sampled mid-cycle
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (out_valid && out_ready) obs_q.push_back('{ch: out_ch, data: out_data, cyc: cyc});
        if (out_valid_t && out_ready) obs_t_q.push_back('{ch: out_ch_t, data: out_data_t, cyc: cyc});
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One rising enable event on a rising-mode channel (stimulus only)
    task automatic pulse_en(input int c, input logic [7:0] d);
        bus[c*8 +: 8] = d;
        en[c] = 1'b1;
        step(4);
        en[c] = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", out_data); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rst_ch got %0d exp 0", out_ch); end
        checks++; if (overrun !== 4'h0) begin errors++; $display("FAIL rst_overrun got %b exp 0000", overrun); end
        checks++; if (out_valid_t !== 1'b0) begin errors++; $display("FAIL rst_valid_t got %b exp 0", out_valid_t); end
        RST = 1'b0;
        step(1);
    endtask

    // Simultaneous captures after reset are served 0,1,2,3 order, back to back
    task automatic test_round_robin();
        logic [3:0] masks [2];
        item_t      e, o;
        logic [31:0] c0;
        int          k;
        masks[0] = 4'b1101;
        masks[1] = 4'b1111;
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) begin
                bus[c*8 +: 8] = 8'(16 * (c + 1) + b);
                if (masks[b][c]) exp_q.push_back('{ch: 2'(c), data: 8'(16 * (c + 1) + b), cyc: 0});
            end
            en = masks[b];
            step(7);
            en = 4'h0;
            step(4);
            for (int t = 0; t < 30 && obs_q.size() < exp_q.size(); t++) step(1);
            if (obs_q.size() < exp_q.size()) begin
                checks++; errors++;
                $display("FAIL rr_timeout got %0d words exp %0d", obs_q.size(), exp_q.size());
            end
            c0 = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
            k = 0;
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o.ch !== e.ch || o.data !== e.data || o.cyc !== c0 + k) begin
                    errors++;
                    $display("FAIL rr_word burst %0d idx %0d got ch%0d %h cyc+%0d exp ch%0d %h cyc+%0d",
                             b, k, o.ch, o.data, o.cyc - c0, e.ch, e.data, k);
                end
                k++;
            end
            exp_q.delete();
            checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rr_extra got %0d extra words exp 0", obs_q.size()); end
            obs_q.delete();
        end
    endtask

    // Single word latency: valid exactly after the 4th edge, for one cycle
    task automatic test_latency();
        item_t e, o;
        out_ready = 1'b1;
        bus[15:8] = 8'hA5;
        en[1] = 1'b1;
        exp_q.push_back('{ch: 2'd1, data: 8'hA5, cyc: 0});
        step(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got valid %b exp 0", out_valid); end
        step(1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'hA5 || out_ch !== 2'd1) begin errors++; $display("FAIL lat_word got ch%0d %h exp ch1 a5", out_ch, out_data); end
        step(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_oneshot got valid %b exp 0", out_valid); end
        en[1] = 1'b0;
        step(4);
        if (obs_q.size() < exp_q.size()) begin checks++; errors++; $display("FAIL lat_missing got %0d words exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.data !== e.data) begin errors++; $display("FAIL lat_sb got ch%0d %h exp ch%0d %h", o.ch, o.data, e.ch, e.data); end
        end
        exp_q.delete();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL lat_extra got %0d extra words exp 0", obs_q.size()); end
        obs_q.delete();
    endtask

    // Stalled output: first word parks in the output, second waits pending,
    // third overwrites the pending one and is flagged as an overrun.
    task automatic test_overrun();
        item_t e, o;
        out_ready = 1'b0;
        pulse_en(0, 8'h11);
        exp_q.push_back('{ch: 2'd0, data: 8'h11, cyc: 0});
        checks++; if (overrun !== 4'h0) begin errors++; $display("FAIL ovr_first got %b exp 0000", overrun); end
        pulse_en(0, 8'h22);
        checks++; if (overrun !== 4'h0) begin errors++; $display("FAIL ovr_second got %b exp 0000", overrun); end
        pulse_en(0, 8'h33);
        exp_q.push_back('{ch: 2'd0, data: 8'h33, cyc: 0});
        checks++; if (overrun !== 4'b0001) begin errors++; $display("FAIL ovr_set got %b exp 0001", overrun); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd0) begin
            errors++; $display("FAIL ovr_stall got v%b ch%0d %h exp v1 ch0 11", out_valid, out_ch, out_data);
        end
        out_ready = 1'b1;
        for (int t = 0; t < 20 && obs_q.size() < exp_q.size(); t++) step(1);
        if (obs_q.size() < exp_q.size()) begin checks++; errors++; $display("FAIL ovr_timeout got %0d words exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.data !== e.data) begin errors++; $display("FAIL ovr_sb got ch%0d %h exp ch%0d %h", o.ch, o.data, e.ch, e.data); end
        end
        exp_q.delete();
        step(3);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ovr_extra got %0d extra words exp 0", obs_q.size()); end
        obs_q.delete();
    endtask

    // Clear coinciding with a fresh ch3 overrun keeps only bit 3
    task automatic test_overrun_clr();
        item_t e, o;
        out_ready = 1'b0;
        pulse_en(3, 8'h01);
        pulse_en(3, 8'h02);
        exp_q.push_back('{ch: 2'd3, data: 8'h01, cyc: 0});
        checks++; if (overrun !== 4'b0001) begin errors++; $display("FAIL clr_pre got %b exp 0001", overrun); end
        bus[31:24] = 8'h03;
        en[3] = 1'b1;
        step(2);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        exp_q.push_back('{ch: 2'd3, data: 8'h03, cyc: 0});
        checks++; if (overrun !== 4'b1000) begin errors++; $display("FAIL clr_same_cycle got %b exp 1000", overrun); end
        en[3] = 1'b0;
        step(3);
        out_ready = 1'b1;
        for (int t = 0; t < 20 && obs_q.size() < exp_q.size(); t++) step(1);
        if (obs_q.size() < exp_q.size()) begin checks++; errors++; $display("FAIL clr_timeout got %0d words exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.data !== e.data) begin errors++; $display("FAIL clr_sb got ch%0d %h exp ch%0d %h", o.ch, o.data, e.ch, e.data); end
        end
        exp_q.delete();
        step(3);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL clr_extra got %0d extra words exp 0", obs_q.size()); end
        obs_q.delete();
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        checks++; if (overrun !== 4'h0) begin errors++; $display("FAIL clr_plain got %b exp 0000", overrun); end
    endtask

    // Toggle mode: both the rise and the fall of enable capture a word
    task automatic test_toggle();
        item_t e, o;
        out_ready = 1'b1;
        bus_t[23:16] = 8'h3C;
        en_t[2] = 1'b1;
        exp_t_q.push_back('{ch: 2'd2, data: 8'h3C, cyc: 0});
        step(5);
        bus_t[23:16] = 8'hC3;
        en_t[2] = 1'b0;
        exp_t_q.push_back('{ch: 2'd2, data: 8'hC3, cyc: 0});
        for (int t = 0; t < 20 && obs_t_q.size() < exp_t_q.size(); t++) step(1);
        if (obs_t_q.size() < exp_t_q.size()) begin checks++; errors++; $display("FAIL tog_timeout got %0d words exp %0d", obs_t_q.size(), exp_t_q.size()); end
        while (exp_t_q.size() > 0 && obs_t_q.size() > 0) begin
            e = exp_t_q.pop_front();
            o = obs_t_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.data !== e.data) begin errors++; $display("FAIL tog_sb got ch%0d %h exp ch%0d %h", o.ch, o.data, e.ch, e.data); end
        end
        exp_t_q.delete();
        step(4);
        checks++; if (obs_t_q.size() != 0) begin errors++; $display("FAIL tog_extra got %0d extra words exp 0", obs_t_q.size()); end
        obs_t_q.delete();
    endtask

    // Reset during a stalled transfer drops everything in flight
    task automatic test_reset_mid();
        item_t e, o;
        out_ready = 1'b0;
        bus[23:0] = 24'h626160;
        en = 4'b0111;
        step(4);
        en = 4'h0;
        step(1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got valid %b exp 1", out_valid); end
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++; $display("FAIL rmid_out got v%b ch%0d %h exp v0 ch0 00", out_valid, out_ch, out_data);
        end
        checks++; if (overrun !== 4'h0) begin errors++; $display("FAIL rmid_ovr got %b exp 0000", overrun); end
        out_ready = 1'b1;
        step(10);
        checks++; if (obs_q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_quiet got %0d words valid %b exp 0 words valid 0", obs_q.size(), out_valid);
        end
        obs_q.delete();
        pulse_en(3, 8'h7E);
        exp_q.push_back('{ch: 2'd3, data: 8'h7E, cyc: 0});
        for (int t = 0; t < 20 && obs_q.size() < exp_q.size(); t++) step(1);
        if (obs_q.size() < exp_q.size()) begin checks++; errors++; $display("FAIL rmid_timeout got %0d words exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.data !== e.data) begin errors++; $display("FAIL rmid_sb got ch%0d %h exp ch%0d %h", o.ch, o.data, e.ch, e.data); end
        end
        exp_q.delete();
        step(3);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_extra got %0d extra words exp 0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        RST         = 1'b1;
        bus         = '0;
        bus_t       = '0;
        en          = '0;
        en_t        = '0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        test_reset();
        test_round_robin();
        test_latency();
        test_overrun();
        test_overrun_clr();
        test_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
